// File: rtl/mem_arb_pkg.sv
// Shared definitions for the CPU/AUX memory arbiter: default sizes, FSM states and owner encoding.
package mem_arb_pkg;

   localparam int unsigned DEF_WIDTH    = 16;
   localparam int unsigned DEF_ADDR_W   = 16;
   localparam int unsigned DEF_MAX_WAIT = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_AUX = 1'b1
   } arb_owner_e;

endpackage

// File: rtl/arb_wait_counter.sv
// Counts cycles the AUX requester waits without a grant; saturates at MAX_WAIT, cleared on aux_gnt.
module arb_wait_counter
   import mem_arb_pkg::*;
#(
   parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
)(
   input  logic clk,
   input  logic reset,
   input  logic aux_req,
   input  logic aux_gnt,
   output logic at_limit_c
);

   localparam int unsigned CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (aux_gnt) begin
         count <= '0;
      end else if (aux_req && (count != CNT_W'(MAX_WAIT))) begin
         count <= count + CNT_W'(1);
      end
   end

   assign at_limit_c = (count == CNT_W'(MAX_WAIT));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU and an AUX port onto one synchronous memory (IDLE -> ACCESS -> RESP for reads).
// Define MEM_ARB_STARVE_GUARD_EN to let a starved AUX requester win ties once it has waited MAX_WAIT cycles.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned WIDTH    = DEF_WIDTH,
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [WIDTH-1:0]  cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [WIDTH-1:0]  cpu_rdata,
   input  logic              aux_req,
   input  logic              aux_we,
   input  logic [ADDR_W-1:0] aux_addr,
   input  logic [WIDTH-1:0]  aux_wdata,
   output logic              aux_gnt,
   output logic              aux_rvalid,
   output logic [WIDTH-1:0]  aux_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WIDTH-1:0]  mem_wdata,
   input  logic [WIDTH-1:0]  mem_rdata
);

   arb_state_e        state_q, state_d;
   arb_owner_e        owner_q, owner_d;
   logic              aux_prio_c;
   logic              grant_c;
   logic              win_we_c;
   logic [ADDR_W-1:0] win_addr_c;
   logic [WIDTH-1:0]  win_wdata_c;
   logic [WIDTH-1:0]  cpu_rdata_q, aux_rdata_q;

`ifdef MEM_ARB_STARVE_GUARD_EN
   arb_wait_counter #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wait_counter (
      .clk        (clk),
      .reset      (reset),
      .aux_req    (aux_req),
      .aux_gnt    (aux_gnt),
      .at_limit_c (aux_prio_c)
   );
`else
   // Strict CPU priority; MAX_WAIT has no effect in this build.
   assign aux_prio_c = 1'b0 & (MAX_WAIT == 0);
`endif

   // Next state, grants and response strobes; grants are gated off while reset is asserted.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      cpu_gnt    = 1'b0;
      aux_gnt    = 1'b0;
      cpu_rvalid = 1'b0;
      aux_rvalid = 1'b0;
      case (state_q)
         IDLE: begin
            if (reset && (cpu_req || aux_req)) begin
               state_d = ACCESS;
               if (aux_req && (!cpu_req || aux_prio_c)) begin
                  aux_gnt = 1'b1;
                  owner_d = OWN_AUX;
               end else begin
                  cpu_gnt = 1'b1;
                  owner_d = OWN_CPU;
               end
            end
         end
         ACCESS: state_d = mem_we ? IDLE : RESP;
         RESP: begin
            state_d    = IDLE;
            cpu_rvalid = (owner_q == OWN_CPU);
            aux_rvalid = (owner_q == OWN_AUX);
         end
         default: state_d = IDLE;
      endcase
   end

   assign grant_c     = cpu_gnt | aux_gnt;
   assign win_we_c    = aux_gnt ? aux_we    : cpu_we;
   assign win_addr_c  = aux_gnt ? aux_addr  : cpu_addr;
   assign win_wdata_c = aux_gnt ? aux_wdata : cpu_wdata;

   // State and memory command registers; mem_en/mem_we are only high in ACCESS.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         owner_q   <= OWN_CPU;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         mem_en  <= grant_c;
         mem_we  <= grant_c & win_we_c;
         if (grant_c) begin
            mem_addr  <= win_addr_c;
            mem_wdata <= win_wdata_c;
         end
      end
   end

   // Read data holding registers, loaded only for the owner in RESP.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cpu_rdata_q <= '0;
         aux_rdata_q <= '0;
      end else begin
         if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
         if (aux_rvalid) aux_rdata_q <= mem_rdata;
      end
   end

   // Bypass so read data is visible in the same cycle as rvalid.
   assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_rdata_q;
   assign aux_rdata = aux_rvalid ? mem_rdata : aux_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: reference model queues expected accesses/responses, monitor checks them.
`timescale 1ns/1ps
module tb_mem_arbiter;

   localparam int unsigned W  = 16;
   localparam int unsigned AW = 16;
   localparam int unsigned MW = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic          clk;
   logic          reset;
   logic          cpu_req, cpu_we, aux_req, aux_we;
   logic [AW-1:0] cpu_addr, aux_addr;
   logic [W-1:0]  cpu_wdata, aux_wdata;
   logic          cpu_gnt, cpu_rvalid, aux_gnt, aux_rvalid;
   logic [W-1:0]  cpu_rdata, aux_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [W-1:0]  mem_wdata;
   logic [W-1:0]  mem_rdata;

   mem_arbiter #(.WIDTH(W), .ADDR_W(AW), .MAX_WAIT(MW)) dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_gnt    (cpu_gnt),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rdata  (cpu_rdata),
      .aux_req    (aux_req),
      .aux_we     (aux_we),
      .aux_addr   (aux_addr),
      .aux_wdata  (aux_wdata),
      .aux_gnt    (aux_gnt),
      .aux_rvalid (aux_rvalid),
      .aux_rdata  (aux_rdata),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [W-1:0]  wdata;
      int unsigned   at;
   } mem_exp_t;

   typedef struct {
      logic         aux;
      logic [W-1:0] data;
      int unsigned  at;
   } rsp_exp_t;

   mem_exp_t     mq[$];
   rsp_exp_t     rq[$];
   logic [W-1:0] bmem [256];
   logic [W-1:0] rmem [256];
   int           total = 0;
   int           bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag(input string name);
      total++;
      bad++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Synchronous memory attached to the mem_* port.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) bmem[mem_addr[7:0]] = mem_wdata;
         else        mem_rdata <= bmem[mem_addr[7:0]];
      end
   end

   // Reference model: who wins each free cycle, how long the port stays busy, what data comes back.
   int busy = 0;
   int wcnt = 0;
   bit m_gcpu = 1'b0;
   bit m_gaux = 1'b0;

   always @(negedge clk) begin
      bit ec, ea;
      ec = 1'b0;
      ea = 1'b0;
      if (!reset) begin
         busy = 0;
         wcnt = 0;
         mq.delete();
         rq.delete();
      end else if (busy > 0) begin
         busy--;
      end else if (cpu_req || aux_req) begin
         ea = aux_req && (!cpu_req || (GUARD && wcnt == MW));
         ec = !ea;
         if (ea) begin
            mq.push_back('{aux_we, aux_addr, aux_wdata, cyc + 1});
            if (aux_we) rmem[aux_addr[7:0]] = aux_wdata;
            else        rq.push_back('{1'b1, rmem[aux_addr[7:0]], cyc + 2});
            busy = aux_we ? 1 : 2;
         end else begin
            mq.push_back('{cpu_we, cpu_addr, cpu_wdata, cyc + 1});
            if (cpu_we) rmem[cpu_addr[7:0]] = cpu_wdata;
            else        rq.push_back('{1'b0, rmem[cpu_addr[7:0]], cyc + 2});
            busy = cpu_we ? 1 : 2;
         end
      end
      if (reset) begin
         if (ea)                         wcnt = 0;
         else if (aux_req && wcnt < MW)  wcnt++;
      end
      check("cpu_gnt", 32'(cpu_gnt), 32'(ec));
      check("aux_gnt", 32'(aux_gnt), 32'(ea));
      m_gcpu = ec;
      m_gaux = ea;
   end

   // Monitor: pops expectations whenever the DUT strobes memory or returns read data.
   logic [W-1:0] exp_cpu_rd = '0;
   logic [W-1:0] exp_aux_rd = '0;

   always @(negedge clk) begin
      mem_exp_t e;
      rsp_exp_t r;
      if (!reset) begin
         exp_cpu_rd = '0;
         exp_aux_rd = '0;
         check("rst_mem_en",    32'(mem_en),     32'(0));
         check("rst_mem_we",    32'(mem_we),     32'(0));
         check("rst_mem_addr",  32'(mem_addr),   32'(0));
         check("rst_mem_wdata", 32'(mem_wdata),  32'(0));
         check("rst_cpu_rvalid",32'(cpu_rvalid), 32'(0));
         check("rst_aux_rvalid",32'(aux_rvalid), 32'(0));
      end else begin
         while (mq.size() > 0 && mq[0].at < cyc) begin
            flag("missing_mem_access");
            void'(mq.pop_front());
         end
         while (rq.size() > 0 && rq[0].at < cyc) begin
            flag("missing_rvalid");
            void'(rq.pop_front());
         end
         if (mem_en) begin
            if (mq.size() == 0) flag("unexpected_mem_access");
            else begin
               e = mq.pop_front();
               check("mem_cycle", 32'(cyc),      32'(e.at));
               check("mem_we",    32'(mem_we),   32'(e.we));
               check("mem_addr",  32'(mem_addr), 32'(e.addr));
               if (e.we) check("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
            end
         end else begin
            check("mem_we_idle", 32'(mem_we), 32'(0));
         end
         if (cpu_rvalid || aux_rvalid) begin
            if (rq.size() == 0) flag("unexpected_rvalid");
            else begin
               r = rq.pop_front();
               check("rsp_cycle", 32'(cyc), 32'(r.at));
               check("rsp_owner", 32'({cpu_rvalid, aux_rvalid}), r.aux ? 32'd1 : 32'd2);
               if (r.aux) exp_aux_rd = r.data;
               else       exp_cpu_rd = r.data;
            end
         end
      end
      check("cpu_rdata", 32'(cpu_rdata), 32'(exp_cpu_rd));
      check("aux_rdata", 32'(aux_rdata), 32'(exp_aux_rd));
   end

   // Stimulus helpers: a request is retired the cycle after the model grants it.
   task automatic tick();
      @(posedge clk);
      #1;
      if (m_gcpu) cpu_req = 1'b0;
      if (m_gaux) aux_req = 1'b0;
   endtask

   task automatic set_cpu(input logic we, input logic [AW-1:0] a, input logic [W-1:0] d);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
   endtask

   task automatic set_aux(input logic we, input logic [AW-1:0] a, input logic [W-1:0] d);
      aux_req = 1'b1; aux_we = we; aux_addr = a; aux_wdata = d;
   endtask

   task automatic wait_idle(input int n);
      int k;
      k = 0;
      while ((cpu_req || aux_req) && k < n) begin
         tick();
         k++;
      end
      if (cpu_req || aux_req) begin
         flag("request_never_granted");
         cpu_req = 1'b0;
         aux_req = 1'b0;
      end
   endtask

   task automatic wait_cpu(input int n);
      int k;
      k = 0;
      while (cpu_req && k < n) begin
         tick();
         k++;
      end
      if (cpu_req) begin
         flag("cpu_request_never_granted");
         cpu_req = 1'b0;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [W-1:0] v;
      for (int i = 0; i < 256; i++) begin
         v = W'($urandom);
         bmem[i] = v;
         rmem[i] = v;
      end
      bmem[8'h10] = 16'hBEEF;
      rmem[8'h10] = 16'hBEEF;
      reset = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      aux_req = 1'b0; aux_we = 1'b0; aux_addr = '0; aux_wdata = '0;

      // CPU read of 0xBEEF, already requesting while reset is held.
      set_cpu(1'b0, 16'h0010, 16'h0000);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      wait_idle(10);
      repeat (3) tick();

      // AUX write.
      set_aux(1'b1, 16'h0200, 16'h1234);
      wait_idle(10);
      repeat (2) tick();

      // Simultaneous reads.
      set_cpu(1'b0, 16'h0008, 16'h0000);
      set_aux(1'b0, 16'h0200, 16'h0000);
      wait_idle(20);
      repeat (3) tick();

      // Back-to-back CPU writes with AUX held.
      set_aux(1'b0, 16'h0010, 16'h0000);
      for (int i = 0; i < 6; i++) begin
         set_cpu(1'b1, AW'(32 + i), W'($urandom));
         wait_cpu(10);
      end
      wait_idle(20);
      repeat (3) tick();

      // AUX pulse during ACCESS, dropped before IDLE.
      set_cpu(1'b0, 16'h0020, 16'h0000);
      wait_cpu(10);
      set_aux(1'b1, 16'h0030, 16'h5555);
      tick();
      aux_req = 1'b0;
      repeat (3) tick();

      // Reset during ACCESS of a CPU read, then a normal read.
      set_cpu(1'b0, 16'h0010, 16'h0000);
      wait_cpu(10);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      repeat (4) tick();
      set_cpu(1'b0, 16'h0200, 16'h0000);
      wait_idle(10);
      repeat (3) tick();

      // Random traffic, including abandoned requests.
      for (int n = 0; n < 1500; n++) begin
         tick();
         if (!cpu_req && $urandom_range(0, 2) == 0)
            set_cpu(1'($urandom), AW'($urandom_range(0, 31)), W'($urandom));
         else if (cpu_req && $urandom_range(0, 30) == 0)
            cpu_req = 1'b0;
         if (!aux_req && $urandom_range(0, 2) == 0)
            set_aux(1'($urandom), AW'($urandom_range(0, 31)), W'($urandom));
         else if (aux_req && $urandom_range(0, 30) == 0)
            aux_req = 1'b0;
      end
      cpu_req = 1'b0;
      aux_req = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("mem_queue_drained", 32'(mq.size()), 32'(0));
      check("rsp_queue_drained", 32'(rq.size()), 32'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters: WIDTH, default 16, data width; ADDR_W, default 16, address width; MAX_WAIT, default 4, aux starvation limit in cycles.
REQ-002 SHALL have ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- cpu_req  input  1  processor access request.
- cpu_we  input  1  1 = write, 0 = read.
- cpu_addr  input  ADDR_W  processor address.
- cpu_wdata  input  WIDTH  processor write data.
- cpu_gnt  output  1  one-cycle grant pulse.
- cpu_rvalid  output  1  read data valid pulse.
- cpu_rdata  output  WIDTH  read data.
- aux_req, aux_we, aux_addr, aux_wdata, aux_gnt, aux_rvalid, aux_rdata: same directions, widths and meanings for the auxiliary (I/O/display) port.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  WIDTH  memory write data.
- mem_rdata  input  WIDTH  synchronous memory read data, valid 1 cycle after mem_en.

Function
REQ-003 SHALL implement FSM states IDLE, ACCESS, RESP; owner register records CPU or AUX.
REQ-004 SHALL arbitrate only in IDLE; a requester holds req/we/addr/wdata stable until its gnt.
REQ-005 SHALL, in IDLE with any req high, assert the winner's gnt combinationally in that cycle (N), register winner's we/addr/wdata onto mem_*, set mem_en=1 and go to ACCESS at N+1.
REQ-006 SHALL, in ACCESS, hold mem_en=1 for exactly one cycle; write -> IDLE at N+2; read -> RESP at N+2.
REQ-007 SHALL, in RESP, pulse owner's rvalid for one cycle with rdata = mem_rdata, then return to IDLE; non-owner rvalid stays 0.
REQ-008 SHALL give read latency gnt-to-rvalid of 2 cycles; next grant no earlier than the cycle after RESP (read) or ACCESS (write).
REQ-009 SHALL grant CPU when only cpu_req is high, AUX when only aux_req is high, and CPU on simultaneous requests unless REQ-014 applies.
REQ-010 SHALL ignore req outside IDLE (no queuing); a req dropped before gnt produces no access.
REQ-011 SHALL drive cpu_rdata/aux_rdata from a register updated only in RESP for the owner; value held otherwise.
REQ-012 SHALL keep mem_en=0 and mem_we=0 in IDLE and RESP.

Reset
REQ-013 SHALL, on reset low at any time (including mid-ACCESS/RESP), go to IDLE immediately; all gnt, rvalid, mem_en, mem_we = 0; mem_addr, mem_wdata, rdata, wait counter = 0; the in-flight access is discarded, no rvalid issued.

Configuration
REQ-014 SHALL, with MEM_ARB_STARVE_GUARD_EN defined, count cycles aux_req is high and not granted (saturating at MAX_WAIT, cleared on aux_gnt) and grant AUX on simultaneous requests when count == MAX_WAIT.
REQ-015 SHALL, without MEM_ARB_STARVE_GUARD_EN, contain no counter and give CPU strict priority.

Structure
REQ-016 SHALL place the state enum, owner encoding and default WIDTH/ADDR_W/MAX_WAIT constants in shared package mem_arb_pkg.
REQ-017 SHALL put the starvation counter in sub-module arb_wait_counter, instantiated only with MEM_ARB_STARVE_GUARD_EN.

Verification
REQ-018 CPU read addr 0x0010, mem holds 0xBEEF -> cpu_gnt at N, mem_en at N+1, cpu_rvalid=1 with cpu_rdata=0xBEEF at N+2, aux_rvalid=0.
REQ-019 AUX write addr 0x0200 data 0x1234 -> aux_gnt at N, mem_en=1, mem_we=1, mem_addr=0x0200, mem_wdata=0x1234 at N+1, IDLE at N+2, no rvalid.
REQ-020 cpu_req and aux_req both high in the same cycle, guard disabled -> cpu_gnt only; aux granted at next IDLE after cpu_req drops.
REQ-021 Guard enabled, MAX_WAIT=4, cpu_req held high with back-to-back writes, aux_req held -> aux_gnt issued once wait count reaches 4; count clears to 0.
REQ-022 reset driven low during ACCESS of a CPU read -> all outputs 0 asynchronously, no cpu_rvalid after release, next request served from IDLE normally.
REQ-023 aux_req pulsed high while FSM in ACCESS and dropped before IDLE -> no aux_gnt, no memory access.
